// File: rtl/acia_txq_pkg.sv
// Shared types and helpers for the queued ACIA transmitter: FSM states,
// parity mode codes, per-frame format record and baud divisor calculation.
package acia_txq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE     = 2'b00,
    PAR_EVEN     = 2'b01,
    PAR_ODD      = 2'b10,
    PAR_NONE_ALT = 2'b11
  } par_mode_e;

  // Frame format captured at pop time and held for the whole frame.
  typedef struct packed {
    logic [1:0] bits;     // data bits minus 5
    logic       par_en;
    logic       par_bit;
    logic       stop2;
  } frame_fmt_t;

  function automatic int sym_cnt_calc(input int clk_freq, input int sym_rate);
    return clk_freq / sym_rate;
  endfunction

  function automatic logic [7:0] data_mask(input logic [1:0] bits);
    return 8'hFF >> (2'd3 - bits);
  endfunction

  function automatic frame_fmt_t make_fmt(input logic [7:0] dat,
                                          input logic [1:0] bits,
                                          input par_mode_e  par,
                                          input logic       stop2);
    frame_fmt_t fmt;
    fmt.bits    = bits;
    fmt.par_en  = (par == PAR_EVEN) || (par == PAR_ODD);
    fmt.par_bit = (^(dat & data_mask(bits))) ^ (par == PAR_ODD);
    fmt.stop2   = stop2;
    return fmt;
  endfunction

endpackage

// File: rtl/acia_txq_fifo.sv
// Byte-wide synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens on the same clock.
module acia_txq_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign rdata   = mem[rd_ptr];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; pointers and level alone decide
  // which entries are valid, so a flush is just a pointer reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/acia_txq.sv
// Queued ACIA transmitter: byte FIFO feeding a runtime-formatted serial framer
// (5-8 data bits, none/even/odd parity, 1 or 2 stop bits) timed by pclk.
module acia_txq
  import acia_txq_pkg::*;
#(
  parameter int clk_freq   = 3333333,
  parameter int sym_rate   = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         pclk,
  input  logic [7:0]                   tx_dat,
  input  logic                         tx_wr,
  input  logic [1:0]                   cfg_bits,
  input  logic [1:0]                   cfg_par,
  input  logic                         cfg_stop2,
  input  logic                         ovf_clr,
  output logic                         tx_serial,
  output logic                         tx_busy,
  output logic                         tx_full,
  output logic                         tx_empty,
  output logic [$clog2(FIFO_DEPTH):0]  tx_level,
  output logic                         tx_ovf
);

  localparam int LW      = $clog2(FIFO_DEPTH) + 1;
  localparam int SYM_CNT = sym_cnt_calc(clk_freq, sym_rate);
  localparam int CW      = $clog2(SYM_CNT);
  localparam logic [CW-1:0] CNT_RELOAD = CW'(SYM_CNT - 1);

  tx_state_e     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  frame_fmt_t    fmt;
  logic          stop_second;

  logic [7:0]    fifo_rdata;
  logic          fifo_full;
  logic          fifo_empty;
  logic          bit_end;
  logic          last_stop;
  logic          pop;
  logic          ovf_set;

  acia_txq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr),
    .pop   (pop),
    .wdata (tx_dat),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (tx_level)
  );

  assign bit_end   = pclk & (cnt == '0);
  assign last_stop = (state == ST_STOP) & (~fmt.stop2 | stop_second);
  // Popping at the end of the last stop bit chains frames with no idle gap.
  assign pop       = pclk & ~fifo_empty & ((state == ST_IDLE) | (bit_end & last_stop));
  assign ovf_set   = tx_wr & fifo_full & ~pop;

  assign tx_full  = fifo_full;
  assign tx_empty = fifo_empty;
  assign tx_busy  = (state != ST_IDLE) | ~fifo_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      fmt         <= '0;
      stop_second <= 1'b0;
      tx_serial   <= 1'b1;
    end else if (pop) begin
      state       <= ST_START;
      cnt         <= CNT_RELOAD;
      bit_idx     <= '0;
      shreg       <= fifo_rdata & data_mask(cfg_bits);
      fmt         <= make_fmt(fifo_rdata, cfg_bits, par_mode_e'(cfg_par), cfg_stop2);
      stop_second <= 1'b0;
      tx_serial   <= 1'b0;
    end else if (state != ST_IDLE && pclk) begin
      if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        cnt <= CNT_RELOAD;
        case (state)
          ST_START: begin
            tx_serial <= shreg[0];
            shreg     <= shreg >> 1;
            bit_idx   <= '0;
            state     <= ST_DATA;
          end
          ST_DATA: begin
            if (bit_idx == {1'b0, fmt.bits} + 3'd4) begin
              if (fmt.par_en) begin
                tx_serial <= fmt.par_bit;
                state     <= ST_PARITY;
              end else begin
                tx_serial <= 1'b1;
                state     <= ST_STOP;
              end
            end else begin
              tx_serial <= shreg[0];
              shreg     <= shreg >> 1;
              bit_idx   <= bit_idx + 1'b1;
            end
          end
          ST_PARITY: begin
            tx_serial <= 1'b1;
            state     <= ST_STOP;
          end
          ST_STOP: begin
            if (fmt.stop2 && !stop_second) stop_second <= 1'b1;
            else                           state       <= ST_IDLE;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Set wins over clear so an overflow coinciding with ovf_clr is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        tx_ovf <= 1'b0;
    else if (ovf_set) tx_ovf <= 1'b1;
    else if (ovf_clr) tx_ovf <= 1'b0;
  end

endmodule

// File: tb/tb_acia_txq.sv
// Self-checking bench for acia_txq: table-driven frame formats checked by a
// line monitor against a scoreboard queue, plus FIFO, reset and pclk sequences.
`timescale 1ns/1ps
module tb_acia_txq;

  localparam int LW = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pclk;
  logic [7:0]    tx_dat = '0;
  logic          tx_wr = 1'b0;
  logic [1:0]    cfg_bits = 2'd3;
  logic [1:0]    cfg_par = 2'd0;
  logic          cfg_stop2 = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          tx_serial, tx_busy, tx_full, tx_empty, tx_ovf;
  logic [LW-1:0] tx_level;

  int   cyc = 0;
  logic div3 = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign pclk = div3 ? (cyc % 3 == 0) : 1'b1;

  acia_txq #(
    .clk_freq   (16),
    .sym_rate   (1),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .pclk      (pclk),
    .tx_dat    (tx_dat),
    .tx_wr     (tx_wr),
    .cfg_bits  (cfg_bits),
    .cfg_par   (cfg_par),
    .cfg_stop2 (cfg_stop2),
    .ovf_clr   (ovf_clr),
    .tx_serial (tx_serial),
    .tx_busy   (tx_busy),
    .tx_full   (tx_full),
    .tx_empty  (tx_empty),
    .tx_level  (tx_level),
    .tx_ovf    (tx_ovf)
  );

  // Frame bits are written in transmission order, right-aligned: bit i on the
  // line is frame[len-1-i].
  typedef struct {
    logic [11:0] frame;
    int          len;
  } exp_t;

  typedef struct {
    logic [7:0]  dat;
    logic [1:0]  bits;
    logic [1:0]  par;
    logic        stop2;
    logic [11:0] frame;
    int          len;
  } vec_t;

  exp_t exp_q[$];
  int   gap_q[$];
  int   bit_clks = 16;
  bit   mon_en = 1'b1;
  int   last_end = 0;
  int   frames_seen = 0;
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t frame_8n1(input logic [7:0] b);
    exp_t e;
    e.frame = '0;
    e.frame[9] = 1'b0;
    for (int i = 0; i < 8; i++) e.frame[8-i] = b[i];
    e.frame[0] = 1'b1;
    e.len = 10;
    return e;
  endfunction

  // Line monitor: on each start bit, pop the next expected frame and compare
  // every clock of every bit period.
  initial begin : monitor
    exp_t f;
    int   nbad;
    int   s;
    forever begin
      @(negedge clk);
      if (mon_en && tx_serial === 1'b0) begin
        s = cyc;
        gap_q.push_back(s - last_end);
        check("frame_expected", exp_q.size() != 0, 1);
        if (exp_q.size() == 0) begin
          for (int k = 0; k < 1000 && tx_serial === 1'b0; k++) @(negedge clk);
        end else begin
          f = exp_q.pop_front();
          nbad = 0;
          for (int k = 0; k < f.len * bit_clks; k++) begin
            if (k != 0) @(negedge clk);
            if (tx_serial !== f.frame[f.len - 1 - k / bit_clks]) nbad++;
          end
          check($sformatf("frame%0d_bad_samples", frames_seen), nbad, 0);
          frames_seen++;
          last_end = s + f.len * bit_clks;
        end
      end
    end
  end

  task automatic wait_idle(input string name, input int budget, output int fall_cyc);
    int n = 0;
    while ((tx_busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_idle_in_time"}, n < budget, 1);
    fall_cyc = cyc;
  endtask

  task automatic write_byte(input logic [7:0] d);
    tx_dat = d;
    tx_wr  = 1'b1;
    @(negedge clk);
    tx_wr  = 1'b0;
  endtask

  initial begin : watchdog
    #400us;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    vec_t vecs[8];
    int   fall;
    int   c0;
    int   lows;

    vecs[0] = '{8'h55, 2'd3, 2'b00, 1'b0, 12'b0101010101,   10}; // 8N1
    vecs[1] = '{8'h41, 2'd2, 2'b01, 1'b1, 12'b01000001011,  11}; // 7E2
    vecs[2] = '{8'h1F, 2'd0, 2'b10, 1'b0, 12'b01111101,      8}; // 5O1
    vecs[3] = '{8'hE3, 2'd0, 2'b10, 1'b1, 12'b011000111,     9}; // 5O2, upper bits ignored
    vecs[4] = '{8'h2A, 2'd1, 2'b00, 1'b0, 12'b00101011,      8}; // 6N1
    vecs[5] = '{8'hA5, 2'd3, 2'b10, 1'b1, 12'b010100101111, 12}; // 8O2
    vecs[6] = '{8'h80, 2'd3, 2'b11, 1'b0, 12'b0000000011,   10}; // parity code 11 = none
    vecs[7] = '{8'hC6, 2'd1, 2'b01, 1'b0, 12'b001100001,     9}; // 6E1

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_serial", tx_serial, 1);
    check("rst_busy",   tx_busy,   0);
    check("rst_full",   tx_full,   0);
    check("rst_empty",  tx_empty,  1);
    check("rst_level",  tx_level,  0);
    check("rst_ovf",    tx_ovf,    0);
    reset = 1'b0;
    @(negedge clk);

    // Frame formats; first negedge after the write shows the byte queued but
    // not yet on the line.
    for (int i = 0; i < 8; i++) begin
      cfg_bits  = vecs[i].bits;
      cfg_par   = vecs[i].par;
      cfg_stop2 = vecs[i].stop2;
      exp_q.push_back('{frame: vecs[i].frame, len: vecs[i].len});
      write_byte(vecs[i].dat);
      check($sformatf("v%0d_level_after_wr", i), tx_level, 1);
      check($sformatf("v%0d_line_idle", i), tx_serial, 1);
      check($sformatf("v%0d_busy", i), tx_busy, 1);
      wait_idle($sformatf("v%0d", i), 400, fall);
      check($sformatf("v%0d_busy_fall_cyc", i), fall, last_end);
    end

    // Config change mid-frame must not alter the frame in flight.
    cfg_bits = 2'd3; cfg_par = 2'b00; cfg_stop2 = 1'b0;
    exp_q.push_back(frame_8n1(8'h55));
    write_byte(8'h55);
    repeat (40) @(negedge clk);
    cfg_bits = 2'd0; cfg_par = 2'b10; cfg_stop2 = 1'b1;
    wait_idle("cfg_mid", 400, fall);
    check("cfg_mid_busy_fall_cyc", fall, last_end);
    cfg_bits = 2'd3; cfg_par = 2'b00; cfg_stop2 = 1'b0;

    // Burst of 6 writes into a depth-4 FIFO: 5 accepted, 1 dropped.
    gap_q.delete();
    c0 = 0;
    for (int i = 0; i < 6; i++) begin
      tx_dat = 8'(i + 1);
      tx_wr  = 1'b1;
      if (i < 5) exp_q.push_back(frame_8n1(8'(i + 1)));
      @(negedge clk);
      if (i == 0) c0 = cyc;
    end
    tx_wr = 1'b0;
    check("burst_level", tx_level, 4);
    check("burst_full",  tx_full,  1);
    check("burst_ovf",   tx_ovf,   1);

    // ovf_clr together with a new overflow keeps the flag set.
    ovf_clr = 1'b1;
    write_byte(8'hEE);
    ovf_clr = 1'b0;
    check("ovf_clr_vs_set", tx_ovf, 1);
    check("ovf_drop_level", tx_level, 4);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check("ovf_cleared", tx_ovf, 0);

    // Write into a full FIFO on the clock a pop happens: accepted.
    while (cyc < c0 + 160) @(negedge clk);
    check("full_before_pop_wr", tx_full, 1);
    exp_q.push_back(frame_8n1(8'h07));
    write_byte(8'h07);
    check("pop_wr_level", tx_level, 4);
    check("pop_wr_no_ovf", tx_ovf, 0);
    wait_idle("burst", 1400, fall);
    check("burst_busy_fall_cyc", fall, last_end);
    check("burst_frames", gap_q.size(), 6);
    for (int i = 1; i < gap_q.size(); i++)
      check($sformatf("burst_gap%0d", i), gap_q[i], 0);

    // Reset mid-frame with a second byte queued.
    mon_en = 1'b0;
    write_byte(8'h5A);
    write_byte(8'h5B);
    repeat (40) @(negedge clk);
    for (int k = 0; k < 100 && tx_serial !== 1'b0; k++) @(negedge clk);
    check("pre_reset_line_low", tx_serial, 0);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_serial", tx_serial, 1);
    check("mid_rst_level",  tx_level,  0);
    check("mid_rst_busy",   tx_busy,   0);
    check("mid_rst_empty",  tx_empty,  1);
    @(negedge clk);
    reset = 1'b0;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx_serial !== 1'b1) lows++;
    end
    check("no_resume_after_rst", lows, 0);
    check("no_resume_busy", tx_busy, 0);
    last_end = cyc;
    mon_en = 1'b1;

    // pclk 1-in-3: bits stretch to 48 clk, writes between pclk are queued.
    div3 = 1'b1;
    bit_clks = 48;
    while (pclk) @(negedge clk);
    exp_q.push_back(frame_8n1(8'h3C));
    write_byte(8'h3C);
    check("pclk_wr_level", tx_level, 1);
    check("pclk_wr_line_idle", tx_serial, 1);
    repeat (100) @(negedge clk);
    while (pclk) @(negedge clk);
    exp_q.push_back(frame_8n1(8'h99));
    write_byte(8'h99);
    check("pclk_wr2_level", tx_level, 1);
    wait_idle("pclk3", 1300, fall);
    check("pclk3_busy_fall_cyc", fall, last_end);
    div3 = 1'b0;
    bit_clks = 16;

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
